// File: rtl/dice_pkg.sv
// Shared state encoding and die-value limits for the electronic-die datapath.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    SHOW = 2'd2
  } state_t;

  localparam logic [3:0] DIE_MIN = 4'd1;
  localparam logic [3:0] DIE_MAX = 4'd6;

  function automatic logic [3:0] die_next(input logic [3:0] v);
    return (v >= DIE_MAX) ? DIE_MIN : v + 4'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability-counter debouncer for a bouncing button.
// rise/fall are single-cycle pulses on transitions of the debounced level db.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s;
  logic          db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s    <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else if (ena) begin
      s1   <= btn;
      s    <= s1;
      db_q <= db;
      if (s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = db & ~db_q;
  assign fall = ~db & db_q;

endmodule

// File: rtl/dice_roller.sv
// Button-driven die: cycles 1..6 while the debounced button is held, freezes
// on release and counts completed rolls (saturating).
module dice_roller
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STEP_DIV        = 1000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             btn,
  input  logic             clr,
  output logic [3:0]       numero,
  output logic             rolling,
  output logic             valid,
  output logic [CNT_W-1:0] roll_count
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

  state_t           state;
  state_t           state_next;
  logic [SW-1:0]    step;
  logic [SW-1:0]    step_next;
  logic [3:0]       numero_next;
  logic [CNT_W-1:0] count_next;
  logic             unused_db;
  logic             rise;
  logic             fall;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .btn  (btn),
    .db   (unused_db),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step       <= '0;
      numero     <= 4'd0;
      roll_count <= '0;
      rolling    <= 1'b0;
      valid      <= 1'b0;
    end else if (ena) begin
      state      <= state_next;
      step       <= step_next;
      numero     <= numero_next;
      roll_count <= count_next;
      rolling    <= (state_next == ROLL);
      valid      <= (state_next == SHOW);
    end
  end

  // clr overrides every button event; the debouncer keeps its own state.
  always_comb begin
    state_next  = state;
    step_next   = step;
    numero_next = numero;
    count_next  = roll_count;
    if (clr) begin
      state_next  = IDLE;
      step_next   = '0;
      numero_next = 4'd0;
      count_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_next  = ROLL;
            numero_next = DIE_MIN;
            step_next   = '0;
          end
        end
        ROLL: begin
          if (fall) begin
            state_next = SHOW;
            if (roll_count != {CNT_W{1'b1}}) count_next = roll_count + 1'b1;
          end else if (step == STEP_LAST) begin
            step_next   = '0;
            numero_next = die_next(numero);
          end else begin
            step_next = step + 1'b1;
          end
        end
        SHOW: begin
          if (rise) begin
            state_next = ROLL;
            step_next  = '0;
          end
        end
        default: begin
          state_next  = IDLE;
          numero_next = 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller: a monitor compares every output change against an
// expected trace (values plus cycle spacing) queued by the directed stimulus.
module tb_dice_roller;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       btn;
  logic       clr;
  logic [3:0] numero;
  logic       rolling;
  logic       valid;
  logic [7:0] roll_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Entry: {gap[7:0], numero[3:0], rolling, valid, roll_count[7:0]}; gap 0 = unchecked.
  logic [21:0] exp_q[$];
  logic        mon_on = 1'b0;

  dice_roller #(
    .DEBOUNCE_CYCLES(4),
    .STEP_DIV       (2),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .btn       (btn),
    .clr       (clr),
    .numero    (numero),
    .rolling   (rolling),
    .valid     (valid),
    .roll_count(roll_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] n, input logic r, input logic v,
                      input int c, input int g);
    exp_q.push_back({g[7:0], n, r, v, c[7:0]});
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] v);
    return (v == 4'd6) ? 4'd1 : v + 4'd1;
  endfunction

  // scoreboard monitor
  initial begin
    logic [13:0] cur;
    logic [13:0] last;
    logic [21:0] e;
    int          gap;
    last = '0;
    gap  = 0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        cur = {numero, rolling, valid, roll_count};
        gap = gap + 1;
        if (cur !== last) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change: got numero=%0d rolling=%0b valid=%0b count=%0d, required no change",
                     cur[13:10], cur[9], cur[8], cur[7:0]);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e[13:0]) begin
              n_bad++;
              $display("FAIL trace: got numero=%0d rolling=%0b valid=%0b count=%0d, required numero=%0d rolling=%0b valid=%0b count=%0d",
                       cur[13:10], cur[9], cur[8], cur[7:0], e[13:10], e[9], e[8], e[7:0]);
            end
            if (e[21:14] != 8'd0) begin
              n_cmp++;
              if (gap != int'(e[21:14])) begin
                n_bad++;
                $display("FAIL gap: got %0d cycles since previous change, required %0d", gap, e[21:14]);
              end
            end
          end
          last = cur;
          gap  = 0;
        end
      end
    end
  end

  // directed stimulus
  initial begin
    logic [3:0] n;
    int         c;
    rst_n = 1'b1;
    ena   = 1'b1;
    btn   = 1'b0;
    clr   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_numero", numero, 0);
    check("reset_rolling", rolling, 0);
    check("reset_valid", valid, 0);
    check("reset_count", roll_count, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    mon_on = 1'b1;

    // glitch of 3 clocks never reaches db
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    tick(20);
    check("glitch_numero", numero, 0);
    check("glitch_rolling", rolling, 0);

    // hold: ROLL exactly 7 clocks after press, steps every 2 clocks
    push(1, 1, 0, 0, 0);
    push(2, 1, 0, 0, 2); push(3, 1, 0, 0, 2); push(4, 1, 0, 0, 2);
    push(5, 1, 0, 0, 2); push(6, 1, 0, 0, 2); push(1, 1, 0, 0, 2);
    push(2, 1, 0, 0, 2);
    push(2, 0, 1, 1, 2);  // SHOW lands on a step cycle; step suppressed
    btn = 1'b1;
    tick(6);
    check("hold_not_yet_rolling", rolling, 0);
    tick(1);
    check("hold_rolling", rolling, 1);
    check("hold_first_value", numero, 1);
    tick(9);
    btn = 1'b0;
    tick(57);
    check("show_valid", valid, 1);
    check("show_numero", numero, 2);
    check("show_count", roll_count, 1);
    check("show_rolling", rolling, 0);

    // re-roll continues from held value; end in SHOW with 4
    push(2, 1, 0, 1, 0); push(3, 1, 0, 1, 2); push(4, 1, 0, 1, 2);
    push(4, 0, 1, 2, 1);
    btn = 1'b1;
    tick(5);
    btn = 1'b0;
    tick(7);
    // press from 4, then clr mid-ROLL
    push(4, 1, 0, 2, 7);
    push(5, 1, 0, 2, 2); push(6, 1, 0, 2, 2); push(1, 1, 0, 2, 2);
    push(2, 1, 0, 2, 2);
    push(0, 0, 0, 0, 2);
    btn = 1'b1;
    tick(16);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(3);
    check("clr_numero", numero, 0);
    check("clr_count", roll_count, 0);
    check("clr_rolling", rolling, 0);
    btn = 1'b0;
    tick(10);

    // ena=0 for 10 clocks mid-ROLL freezes value and step counter
    push(1, 1, 0, 0, 0); push(2, 1, 0, 0, 2); push(3, 1, 0, 0, 2);
    push(4, 1, 0, 0, 12);
    push(5, 1, 0, 0, 2); push(6, 1, 0, 0, 2); push(1, 1, 0, 0, 2);
    push(2, 1, 0, 0, 2);
    push(2, 0, 1, 1, 2);
    btn = 1'b1;
    tick(12);
    ena = 1'b0;
    tick(5);
    check("ena_frozen_numero", numero, 3);
    tick(5);
    ena = 1'b1;
    tick(4);
    btn = 1'b0;
    tick(10);

    // 300 short rolls saturate the counter
    n = 4'd2;
    c = 1;
    for (int i = 0; i < 300; i++) begin
      push(n, 1, 0, c, 0);
      push(nxt(n), 1, 0, c, 2);
      push(nxt(nxt(n)), 1, 0, c, 2);
      n = nxt(nxt(nxt(n)));
      push(n, 1, 0, c, 2);
      c = (c == 255) ? 255 : c + 1;
      push(n, 0, 1, c, 1);
      btn = 1'b1;
      tick(7);
      btn = 1'b0;
      tick(7);
    end
    tick(2);
    check("sat_count", roll_count, 255);
    check("sat_valid", valid, 1);

    // asynchronous reset mid-roll
    push(n, 1, 0, 255, 0);
    push(0, 0, 0, 0, 0);
    btn = 1'b1;
    tick(8);
    rst_n = 1'b0;
    #1;
    check("arst_numero", numero, 0);
    check("arst_rolling", rolling, 0);
    check("arst_valid", valid, 0);
    check("arst_count", roll_count, 0);
    btn = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(12);

    // final report
    while (exp_q.size() != 0) begin
      logic [21:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_change: got nothing, required numero=%0d rolling=%0b valid=%0b count=%0d",
               e[13:10], e[9], e[8], e[7:0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
